// File: rtl/alu_muldiv_seq.sv
// RV32M multiply/divide sequencer that borrows the core ALU for a fixed 36-cycle schedule.
// Define MULDIV_DIV_EN to build the divide/remainder path; otherwise those ops return rsp_illegal.
module alu_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_illegal,
  output logic            busy,
  output logic [XLEN-1:0] alu_InA,
  output logic [XLEN-1:0] alu_InB,
  output logic            alu_Cin,
  output logic            alu_invA,
  output logic            alu_invB,
  output logic            alu_Sign,
  output logic [2:0]      alu_Oper,
  input  logic [XLEN-1:0] alu_Out,
  input  logic            alu_Ofl
);

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FIX_LO, S_FIX_HI, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] hi, lo;
  logic [4:0]      cnt;
  logic            neg_lo, neg_hi;
  logic            a_signed, b_signed, sa, sb;
  logic            is_div;
  logic [XLEN-1:0] result;
  logic            illegal;
  logic [XLEN-1:0] neg_b_val;

`ifdef MULDIV_DIV_EN
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] r_shift;
  assign is_div  = op_q[2];
  assign r_shift = {hi[XLEN-2:0], lo[XLEN-1]};
`else
  assign is_div = 1'b0;
`endif

  assign a_signed  = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
  assign b_signed  = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
  assign sa        = a_signed & a_q[XLEN-1];
  assign sb        = b_signed & b_q[XLEN-1];
  assign neg_b_val = sb ? alu_Out : b_q;

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign alu_Sign  = 1'b0;
  assign alu_Oper  = 3'b100;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and ALU drive; the ALU inverts-and-increments an operand when its inv flag is set.
  always_comb begin
    state_d  = state_q;
    alu_InA  = '0;
    alu_InB  = '0;
    alu_Cin  = 1'b0;
    alu_invA = 1'b0;
    alu_invB = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) state_d = S_NEG_A;
      end
      S_NEG_A: begin
        alu_InA  = a_q;
        alu_invA = 1'b1;
        state_d  = S_NEG_B;
      end
      S_NEG_B: begin
        alu_InA  = b_q;
        alu_invA = 1'b1;
        state_d  = S_ITER;
      end
      S_ITER: begin
`ifdef MULDIV_DIV_EN
        if (is_div) begin
          alu_InA  = r_shift;
          alu_invB = 1'b1;
          alu_InB  = mag_b;
        end else begin
          alu_InA = hi;
          alu_InB = lo[0] ? mag_a : '0;
        end
`else
        alu_InA = hi;
        alu_InB = lo[0] ? mag_a : '0;
`endif
        if (cnt == 5'd31) state_d = S_FIX_LO;
      end
      S_FIX_LO: begin
        if (neg_lo) begin
          alu_InA  = lo;
          alu_invA = 1'b1;
        end
        state_d = S_FIX_HI;
      end
      S_FIX_HI: begin
        // A remainder is negated on its own, so it always takes the carry-in.
        if (neg_hi) begin
          alu_InA  = hi;
          alu_invA = 1'b1;
          alu_InB  = '1;
          alu_Cin  = is_div | (lo == '0);
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_valid && rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    result  = (op_q[1:0] == 2'b00) ? lo : hi;
`ifdef MULDIV_DIV_EN
    illegal = 1'b0;
    if (op_q[2]) begin
      result = op_q[1] ? hi : lo;
      if (b_q == '0) result = op_q[1] ? a_q : '1;
    end
`else
    illegal = op_q[2];
    if (op_q[2]) result = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mag_a       <= '0;
      hi          <= '0;
      lo          <= '0;
      cnt         <= '0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_illegal <= 1'b0;
`ifdef MULDIV_DIV_EN
      mag_b       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q <= req_op;
            a_q  <= req_a;
            b_q  <= req_b;
          end
        end
        S_NEG_A: mag_a <= sa ? alu_Out : a_q;
        S_NEG_B: begin
          hi     <= '0;
          lo     <= is_div ? mag_a : neg_b_val;
          cnt    <= '0;
          neg_lo <= sa ^ sb;
          neg_hi <= is_div ? sa : (sa ^ sb);
`ifdef MULDIV_DIV_EN
          mag_b  <= neg_b_val;
`endif
        end
        S_ITER: begin
          cnt <= cnt + 5'd1;
`ifdef MULDIV_DIV_EN
          if (is_div) begin
            if (hi[XLEN-1] | alu_Ofl) begin
              hi <= alu_Out;
              lo <= {lo[XLEN-2:0], 1'b1};
            end else begin
              hi <= r_shift;
              lo <= {lo[XLEN-2:0], 1'b0};
            end
          end else begin
            hi <= {alu_Ofl, alu_Out[XLEN-1:1]};
            lo <= {alu_Out[0], lo[XLEN-1:1]};
          end
`else
          hi <= {alu_Ofl, alu_Out[XLEN-1:1]};
          lo <= {alu_Out[0], lo[XLEN-1:1]};
`endif
        end
        S_FIX_LO: if (neg_lo) lo <= alu_Out;
        S_FIX_HI: if (neg_hi) hi <= alu_Out;
        S_DONE: begin
          if (!rsp_valid) begin
            rsp_valid   <= 1'b1;
            rsp_data    <= result;
            rsp_illegal <= illegal;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
      if (flush) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: supplies a behavioural ALU and checks results
// against plain-arithmetic RV32M reference values, plus handshake, flush and reset behaviour.
module tb_alu_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_illegal;
  logic        busy;
  logic [31:0] alu_InA, alu_InB, alu_Out;
  logic        alu_Cin, alu_invA, alu_invB, alu_Sign, alu_Ofl;
  logic [2:0]  alu_Oper;
  logic [33:0] alu_sum;

  int n_cmp = 0;
  int n_err = 0;

  alu_muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_illegal(rsp_illegal), .busy(busy),
    .alu_InA(alu_InA), .alu_InB(alu_InB), .alu_Cin(alu_Cin),
    .alu_invA(alu_invA), .alu_invB(alu_invB), .alu_Sign(alu_Sign),
    .alu_Oper(alu_Oper), .alu_Out(alu_Out), .alu_Ofl(alu_Ofl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Core ALU: an inv flag negates that operand (two's complement); Ofl is the unsigned carry-out.
  always_comb begin
    alu_sum = (alu_invA ? ({2'b00, ~alu_InA} + 34'd1) : {2'b00, alu_InA})
            + (alu_invB ? ({2'b00, ~alu_InB} + 34'd1) : {2'b00, alu_InB})
            + {33'd0, alu_Cin};
  end
  assign alu_Out = alu_sum[31:0];
  assign alu_Ofl = |alu_sum[33:32];

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'b000:  p = {32'd0, a} * {32'd0, b};
      3'b001:  p = sa * sb;
      3'b010:  p = sa * longint'({32'd0, b});
      3'b011:  p = {32'd0, a} * {32'd0, b};
      default: p = '0;
    endcase
    if (op == 3'b000) return p[31:0];
    if (!op[2]) return p[63:32];
`ifdef MULDIV_DIV_EN
    if (b == 32'd0) return op[1] ? a : 32'hFFFFFFFF;
    case (op)
      3'b100:  p = sa / sb;
      3'b101:  p = {32'd0, a / b};
      3'b110:  p = sa % sb;
      default: p = {32'd0, a % b};
    endcase
    return p[31:0];
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic ref_illegal(input logic [2:0] op);
`ifdef MULDIV_DIV_EN
    return 1'b0 & op[2];
`else
    return op[2];
`endif
  endfunction

  // Issue one request from an idle DUT; returns edges from accept until rsp_valid is seen.
  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output int lat);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_response();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_illegal !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_handshake: got rdy=%b vld=%b data=%h ill=%b busy=%b expected 1 0 0 0 0",
               req_ready, rsp_valid, rsp_data, rsp_illegal, busy);
    end
    n_cmp++;
    if (alu_InA !== 32'd0 || alu_InB !== 32'd0 || alu_Cin !== 1'b0 || alu_invA !== 1'b0 ||
        alu_invB !== 1'b0 || alu_Sign !== 1'b0 || alu_Oper !== 3'b100) begin
      n_err++;
      $display("[TB] FAIL reset_alu: got A=%h B=%h cin=%b ia=%b ib=%b sign=%b oper=%b expected zeros, oper 100",
               alu_InA, alu_InB, alu_Cin, alu_invA, alu_invB, alu_Sign, alu_Oper);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic test_directed();
    vec_t vecs [13];
    int lat;
    logic [31:0] exp;
    vecs = '{
      '{3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB},
      '{3'b001, 32'h80000000,  32'h80000000, 32'h40000000},
      '{3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE},
      '{3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF},
      '{3'b100, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD},
      '{3'b110, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF},
      '{3'b101, 32'hFFFFFFFF,  32'd3,        32'h55555555},
      '{3'b100, 32'd5,         32'd0,        32'hFFFFFFFF},
      '{3'b111, 32'd5,         32'd0,        32'd5},
      '{3'b100, 32'h80000000,  32'hFFFFFFFF, 32'h80000000},
      '{3'b110, 32'h80000000,  32'hFFFFFFFF, 32'd0},
      '{3'b101, 32'd9,         32'd3,        32'd3},
      '{3'b000, 32'd6,         32'd7,        32'd42}
    };
    for (int i = 0; i < 13; i++) begin
`ifdef MULDIV_DIV_EN
      exp = vecs[i].exp;
`else
      exp = vecs[i].op[2] ? 32'd0 : vecs[i].exp;
`endif
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      n_cmp++;
      if (lat !== 37) begin
        n_err++;
        $display("[TB] FAIL directed_latency[%0d]: got %0d edges expected 37", i, lat);
      end
      n_cmp++;
      if (rsp_data !== exp || rsp_illegal !== ref_illegal(vecs[i].op)) begin
        n_err++;
        $display("[TB] FAIL directed_result[%0d] op=%b a=%h b=%h: got %h ill=%b expected %h ill=%b",
                 i, vecs[i].op, vecs[i].a, vecs[i].b, rsp_data, rsp_illegal, exp, ref_illegal(vecs[i].op));
      end
      release_response();
    end
  endtask

  task automatic test_random();
    int lat;
    logic [2:0] op;
    logic [31:0] a, b, exp;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = 32'($urandom_range(0, 20)) - 32'd10; b = 32'($urandom_range(0, 20)) - 32'd10; end
        default: ;
      endcase
      exp = ref_result(op, a, b);
      apply_stimulus(op, a, b, lat);
      n_cmp++;
      if (lat !== 37 || rsp_data !== exp || rsp_illegal !== ref_illegal(op)) begin
        n_err++;
        $display("[TB] FAIL random[%0d] op=%b a=%h b=%h: got %h ill=%b lat=%0d expected %h ill=%b lat=37",
                 i, op, a, b, rsp_data, rsp_illegal, lat, exp, ref_illegal(op));
      end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      release_response();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] a, b, exp;
    a = $urandom;
    b = $urandom;
    exp = ref_result(3'b011, a, b);
    apply_stimulus(3'b011, a, b, lat);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp || req_ready !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL backpressure[%0d]: got vld=%b data=%h rdy=%b expected 1 %h 0",
                 i, rsp_valid, rsp_data, req_ready, exp);
      end
      @(posedge clk); #1;
    end
    release_response();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    apply_stimulus(3'b001, a, b, lat);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_op = 3'b000; req_a = 32'd1234; req_b = 32'd5678;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL b2b_return_idle: got busy=%b rdy=%b vld=%b expected 0 1 0", busy, req_ready, rsp_valid);
    end
    apply_stimulus(3'b000, 32'd1234, 32'd5678, lat);
    n_cmp++;
    if (lat !== 37 || rsp_data !== 32'd7006652) begin
      n_err++;
      $display("[TB] FAIL b2b_second: got %h lat=%0d expected %h lat=37", rsp_data, lat, 32'd7006652);
    end
    release_response();
  endtask

  task automatic test_flush();
    int seen;
    int lat;
    req_op = 3'b101; req_a = 32'd100; req_b = 32'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    n_cmp++;
    if (busy !== 1'b1 || req_ready !== 1'b0 || alu_Oper !== 3'b100 || alu_Sign !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL flush_midop: got busy=%b rdy=%b oper=%b sign=%b expected 1 0 100 0",
               busy, req_ready, alu_Oper, alu_Sign);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_InA !== 32'd0 || alu_InB !== 32'd0) begin
      n_err++;
      $display("[TB] FAIL flush_idle: got busy=%b rdy=%b vld=%b A=%h B=%h expected 0 1 0 0 0",
               busy, req_ready, rsp_valid, alu_InA, alu_InB);
    end
    seen = 0;
    repeat (45) begin
      if (rsp_valid) seen++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("[TB] FAIL flush_no_response: got %0d valid cycles expected 0", seen);
    end
    apply_stimulus(3'b000, 32'd6, 32'd7, lat);
    n_cmp++;
    if (lat !== 37 || rsp_data !== 32'd42) begin
      n_err++;
      $display("[TB] FAIL flush_recover: got %h lat=%0d expected 0000002a lat=37", rsp_data, lat);
    end
    release_response();
  endtask

  task automatic test_async_reset();
    int lat;
    req_op = 3'b001; req_a = $urandom; req_b = $urandom; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_illegal !== 1'b0 ||
        busy !== 1'b0 || alu_InA !== 32'd0 || alu_InB !== 32'd0 || alu_Cin !== 1'b0 ||
        alu_invA !== 1'b0 || alu_invB !== 1'b0 || alu_Oper !== 3'b100) begin
      n_err++;
      $display("[TB] FAIL async_reset: got rdy=%b vld=%b data=%h ill=%b busy=%b A=%h B=%h cin=%b ia=%b ib=%b oper=%b expected reset values",
               req_ready, rsp_valid, rsp_data, rsp_illegal, busy, alu_InA, alu_InB, alu_Cin,
               alu_invA, alu_invB, alu_Oper);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    apply_stimulus(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    n_cmp++;
    if (lat !== 37 || rsp_data !== 32'hFFFFFFFE) begin
      n_err++;
      $display("[TB] FAIL reset_recover: got %h lat=%0d expected fffffffe lat=37", rsp_data, lat);
    end
    release_response();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
